// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: text-mode geometry, clear code and clear FSM states shared by the display path
package vram_arbiter_pkg;
   localparam int COLS = 80;
   localparam int ROWS = 30;
   localparam int CHAR_W = 8;
   localparam int CHAR_H = 16;
   localparam int ADDR_W = 12;
   localparam int CW_L = $clog2(CHAR_W);
   localparam int CH_L = $clog2(CHAR_H);
   localparam int CELLS = COLS * ROWS;
   localparam logic [7:0] BLANK_CHAR = 8'h20;
   typedef enum logic {IDLE, CLEAR} clr_state_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: timing, display, writer, clear and text RAM signals around the arbiter
interface vram_arbiter_if;
   import vram_arbiter_pkg::*;
   logic [9:0] h_addr, v_addr;
   logic valid;
   logic [7:0] disp_char;
   logic disp_strobe;
   logic wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0] wr_data;
   logic wr_ack;
   logic clr_req;
   logic clr_busy;
   logic [ADDR_W-1:0] ram_addr;
   logic ram_we;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   modport slave (input h_addr, v_addr, valid, wr_req, wr_addr, wr_data, clr_req, ram_rdata,
                  output disp_char, disp_strobe, wr_ack, clr_busy, ram_addr, ram_we, ram_wdata);
   modport master (output h_addr, v_addr, valid, wr_req, wr_addr, wr_data, clr_req, ram_rdata,
                   input disp_char, disp_strobe, wr_ack, clr_busy, ram_addr, ram_we, ram_wdata);
endinterface

// File: rtl/vram_addr_calc.sv
// vram_addr_calc: pixel position to text cell address, row*80 done as (row<<6)+(row<<4)
module vram_addr_calc
   import vram_arbiter_pkg::*;
(
   input  logic [9:0]        h_addr,
   input  logic [9:0]        v_addr,
   output logic [ADDR_W-1:0] addr
);
   logic [ADDR_W-1:0] row, col;
   assign row = ADDR_W'(v_addr >> CH_L);
   assign col = ADDR_W'(h_addr >> CW_L);
   assign addr = (row << 6) + (row << 4) + col;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port text RAM between display fetch, screen clear and the editor writer
module vram_arbiter
   import vram_arbiter_pkg::*;
(
   input logic pclk,
   input logic reset,
   vram_arbiter_if.slave bus
);
   clr_state_t state;
   logic [ADDR_W-1:0] clr_addr, last_addr, disp_addr;
   logic slot, slot_d, clr_go, wr_go;
   vram_addr_calc u_calc (.h_addr(bus.h_addr), .v_addr(bus.v_addr), .addr(disp_addr));
   assign slot = bus.valid && bus.h_addr[CW_L-1:0] == '0;
   // reset gating keeps the RAM untouched while the pipeline is held
   assign clr_go = !reset && !slot && state == CLEAR;
   assign wr_go = !reset && !slot && state == IDLE && bus.wr_req;
   assign bus.ram_addr = slot ? disp_addr : clr_go ? clr_addr : wr_go ? bus.wr_addr : last_addr;
   assign bus.ram_we = clr_go || (wr_go && bus.wr_addr < ADDR_W'(CELLS));
   assign bus.ram_wdata = clr_go ? BLANK_CHAR : bus.wr_data;
   assign bus.wr_ack = wr_go;
   assign bus.clr_busy = state == CLEAR;
   always_ff @(posedge pclk or posedge reset)
      if (reset) begin
         state <= CLEAR;
         clr_addr <= '0;
         last_addr <= '0;
         slot_d <= 1'b0;
         bus.disp_char <= BLANK_CHAR;
         bus.disp_strobe <= 1'b0;
      end else begin
         last_addr <= bus.ram_addr;
         slot_d <= slot;
         bus.disp_strobe <= slot_d;
         if (slot_d) bus.disp_char <= bus.ram_rdata;
         if (state == IDLE && bus.clr_req) state <= CLEAR;
         else if (clr_go) begin
            clr_addr <= clr_addr == ADDR_W'(CELLS - 1) ? '0 : clr_addr + 1'b1;
            if (clr_addr == ADDR_W'(CELLS - 1)) state <= IDLE;
         end
      end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of fetch timing, writer arbitration and the clear engine
module tb_vram_arbiter;
   logic pclk, reset;
   logic ld_en;
   logic [11:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] mem [0:4095];
   int tests = 0, fails = 0;
   int clr_writes = 0, all_writes = 0, seq_err = 0, slot_err = 0, exp_next = 0, last_clr = -1;
   int hc, c0, ack_err;
   logic done;
   vram_arbiter_if bus ();
   vram_arbiter dut (.pclk(pclk), .reset(reset), .bus(bus));
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;
   always @(posedge pclk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end
   always @(posedge pclk) begin
      if (reset) exp_next <= 0;
      else if (bus.ram_we) begin
         all_writes <= all_writes + 1;
         if (bus.valid && bus.h_addr[2:0] == 3'd0) slot_err <= slot_err + 1;
         if (bus.clr_busy) begin
            clr_writes <= clr_writes + 1;
            last_clr <= int'(bus.ram_addr);
            if (int'(bus.ram_addr) != exp_next || bus.ram_wdata != 8'h20) seq_err <= seq_err + 1;
            exp_next <= bus.ram_addr == 12'd2399 ? 0 : int'(bus.ram_addr) + 1;
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      bus.h_addr = '0; bus.v_addr = '0; bus.valid = 1'b0;
      bus.wr_req = 1'b1; bus.wr_addr = 12'd3; bus.wr_data = 8'h33; bus.clr_req = 1'b0;
      @(negedge pclk); @(negedge pclk); #1;
      chk("rst_busy", bus.clr_busy, 1);
      chk("rst_we", bus.ram_we, 0);
      chk("rst_ack", bus.wr_ack, 0);
      chk("rst_char", bus.disp_char, 8'h20);
      chk("rst_strobe", bus.disp_strobe, 0);
      reset = 1'b0; bus.wr_req = 1'b0;
      hc = 0; done = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge pclk);
         hc = (hc + 1) % 800;
         bus.valid = hc < 640;
         bus.h_addr = hc < 640 ? 10'(hc) : 10'd0;
         #1;
         if (!bus.clr_busy) begin done = 1'b1; break; end
      end
      chk("clr_done", done, 1);
      chk("clr_count", clr_writes, 2400);
      chk("clr_seq", seq_err, 0);
      chk("clr_slot", slot_err, 0);
      chk("clr_last", last_clr, 2399);
      bus.valid = 1'b0; bus.h_addr = '0;
      repeat (50) @(negedge pclk);
      chk("post_clr_quiet", all_writes, 2400);
      ld_en = 1'b1; ld_addr = 12'd81; ld_data = 8'h41;
      @(negedge pclk); ld_en = 1'b0;
      @(negedge pclk);
      bus.valid = 1'b1; bus.h_addr = 10'd8; bus.v_addr = 10'd16; #1;
      chk("fetch_addr", bus.ram_addr, 81);
      chk("fetch_we", bus.ram_we, 0);
      @(negedge pclk); bus.h_addr = 10'd9; #1;
      chk("fetch_lat1", bus.disp_strobe, 0);
      @(negedge pclk); bus.valid = 1'b0; bus.h_addr = '0; bus.v_addr = '0; #1;
      chk("fetch_char", bus.disp_char, 8'h41);
      chk("fetch_strobe", bus.disp_strobe, 1);
      @(negedge pclk); #1;
      chk("strobe_pulse", bus.disp_strobe, 0);
      chk("char_hold", bus.disp_char, 8'h41);
      bus.wr_req = 1'b1; bus.wr_addr = 12'd5; bus.wr_data = 8'h5A; #1;
      chk("wr_we", bus.ram_we, 1);
      chk("wr_addr", bus.ram_addr, 5);
      chk("wr_data", bus.ram_wdata, 8'h5A);
      chk("wr_ack", bus.wr_ack, 1);
      @(negedge pclk); bus.wr_req = 1'b0; #1;
      chk("wr_ack_drop", bus.wr_ack, 0);
      @(negedge pclk); bus.valid = 1'b1; bus.h_addr = 10'd40; bus.v_addr = 10'd0;
      @(negedge pclk); bus.valid = 1'b0; bus.h_addr = '0;
      @(negedge pclk); #1;
      chk("wr_readback", bus.disp_char, 8'h5A);
      bus.valid = 1'b1; bus.h_addr = 10'd16; bus.wr_req = 1'b1; bus.wr_addr = 12'd7; bus.wr_data = 8'h37; #1;
      chk("slot_ack", bus.wr_ack, 0);
      chk("slot_we", bus.ram_we, 0);
      chk("slot_addr", bus.ram_addr, 2);
      @(negedge pclk); bus.h_addr = 10'd17; #1;
      chk("stall_ack", bus.wr_ack, 1);
      chk("stall_we", bus.ram_we, 1);
      chk("stall_addr", bus.ram_addr, 7);
      @(negedge pclk); bus.valid = 1'b0; bus.h_addr = '0; bus.wr_addr = 12'd2400; bus.wr_data = 8'h55; #1;
      chk("stall_mem", mem[7], 8'h37);
      chk("oob_ack", bus.wr_ack, 1);
      chk("oob_we", bus.ram_we, 0);
      @(negedge pclk); bus.wr_req = 1'b0; bus.clr_req = 1'b1; #1;
      chk("clr_req_idle", bus.clr_busy, 0);
      @(negedge pclk); bus.clr_req = 1'b0; #1;
      chk("clr2_busy", bus.clr_busy, 1);
      chk("clr2_addr0", bus.ram_addr, 0);
      chk("clr2_we", bus.ram_we, 1);
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge pclk); #1;
         if (last_clr == 999) begin done = 1'b1; break; end
      end
      chk("clr2_reach", done, 1);
      bus.clr_req = 1'b1; #1;
      chk("clr2_at1000", bus.ram_addr, 1000);
      @(negedge pclk); bus.clr_req = 1'b0; #1;
      chk("clr2_norestart", bus.ram_addr, 1001);
      chk("clr2_still", bus.clr_busy, 1);
      reset = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 12'd9; bus.wr_data = 8'h39; #1;
      chk("midrst_we", bus.ram_we, 0);
      chk("midrst_busy", bus.clr_busy, 1);
      @(negedge pclk); #1;
      chk("midrst_ack", bus.wr_ack, 0);
      reset = 1'b0; #1;
      chk("restart_addr", bus.ram_addr, 0);
      chk("restart_we", bus.ram_we, 1);
      chk("restart_ack", bus.wr_ack, 0);
      c0 = clr_writes; ack_err = 0; done = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge pclk); #1;
         if (bus.wr_ack && bus.clr_busy) ack_err++;
         if (bus.wr_ack) begin done = 1'b1; break; end
      end
      chk("late_ack", done, 1);
      chk("late_ack_busy", bus.clr_busy, 0);
      chk("late_ack_addr", bus.ram_addr, 9);
      chk("late_ack_we", bus.ram_we, 1);
      chk("ack_in_clear", ack_err, 0);
      chk("restart_count", clr_writes - c0, 2400);
      chk("restart_seq", seq_err, 0);
      @(negedge pclk); bus.wr_req = 1'b0; #1;
      chk("late_mem", mem[9], 8'h39);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Arbiter and sequencer for the single-port text RAM that feeds the VGA character display. It shares the RAM between three requesters:
- the display fetch path, driven by the pixel coordinates coming from the VGA timing block;
- an internal screen-clear engine;
- an external writer port used by the keyboard/text editor logic.

It sits between the VGA timing block, the editor logic, and the text RAM instance. Its output character code goes to the font ROM stage.

Parameters:
COLS, 80, characters per text row
ROWS, 30, text rows per screen
CHAR_W, 8, pixel width of a glyph cell (power of two)
CHAR_H, 16, pixel height of a glyph cell (power of two)
ADDR_W, 12, text RAM address width (must cover COLS*ROWS)
BLANK_CHAR, 8'h20, code written by the clear engine

Ports:
pclk  in  1  25 MHz pixel clock
reset  in  1  asynchronous, active-high
h_addr  in  10  current active pixel x (0 when not valid)
v_addr  in  10  current active pixel y (0 when not valid)
valid  in  1  active-video indicator from timing block
disp_char  out  8  character code for current glyph cell
disp_strobe  out  1  one-cycle pulse when disp_char updates
wr_req  in  1  writer request, held high until acked
wr_addr  in  ADDR_W  writer target address (row*COLS+col)
wr_data  in  8  writer character code
wr_ack  out  1  one-cycle pulse: request consumed
clr_req  in  1  pulse: start screen clear
clr_busy  out  1  high while clear engine runs
ram_addr  out  ADDR_W  text RAM address
ram_we  out  1  text RAM write enable
ram_wdata  out  8  text RAM write data
ram_rdata  in  8  text RAM read data (1-cycle synchronous read)

Behaviour:
- Fetch slot: a cycle with valid=1 and h_addr[log2(CHAR_W)-1:0]==0. The display owns the RAM unconditionally in that cycle.
  - ram_addr = (v_addr>>log2 CHAR_H)*COLS + (h_addr>>log2 CHAR_W); ram_we=0.
- Display latency: ram_rdata is valid 1 cycle after the slot and is registered into disp_char. disp_char and disp_strobe therefore change 2 cycles after the slot. disp_char holds until the next strobe.
- Free cycles are all non-slot cycles. Priority in free cycles is clear engine, then writer.
- Clear FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req.
  - In CLEAR, each free cycle writes BLANK_CHAR to clr_addr, then clr_addr increments.
  - After the write to COLS*ROWS-1: CLEAR -> IDLE and clr_addr returns to 0.
  - clr_req during CLEAR is ignored; the clear does not restart.
- clr_busy = (state==CLEAR).
- Writer handshake:
  - When wr_req=1, the state is IDLE and the cycle is free: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, and wr_ack=1 in the same cycle.
  - wr_req must drop or change data in the cycle after wr_ack. A request still high after an ack is treated as a new request.
  - If wr_addr >= COLS*ROWS, the request is acked with ram_we=0, so no RAM corruption.
  - wr_req during a slot or during CLEAR stalls: wr_ack=0 and the request is held.
- Idle cycles: ram_we=0 and ram_addr holds its last value.
- ram_addr, ram_we, ram_wdata and wr_ack are combinational from the arbitration decision. disp_char, disp_strobe, FSM state and clr_addr are registered.
- Reset values:
  - state=CLEAR, clr_addr=0, disp_char=BLANK_CHAR, disp_strobe=0, wr_ack=0, ram_we=0, clr_busy=1.
  - The screen is therefore auto-cleared after reset release.
- Reset mid-clear restarts the clear from address 0.
- A pending read pipeline stage is dropped on reset.
- Blanking: the horizontal blank is ~160 free cycles per line, and 7 of every 8 active cycles are free. A full clear completes within one frame.

Decomposition:
- Shared package: COLS, ROWS, CHAR_W, CHAR_H, BLANK_CHAR, ADDR_W, and the clear FSM state enum (IDLE, CLEAR). The font ROM stage reuses these.
- One natural sub-module: vram_addr_calc, the row*COLS+col address computation.
  - Implement the multiply by shift-add for COLS=80: (row<<6)+(row<<4).
  - The display path and the editor cursor logic both use it.

Test Plan:
1. Reset release, no requests -> clr_busy high. Exactly 2400 writes of 8'h20 to addresses 0..2399 with no write during any fetch slot. clr_busy falls; no further ram_we.
2. RAM preloaded addr 81 = 8'h41; drive h_addr=8, v_addr=16, valid=1 -> ram_addr=81 in that cycle. disp_char=8'h41 with disp_strobe 2 cycles later.
3. After clear: wr_req with wr_addr=5, wr_data=8'h5A during a free cycle -> same-cycle ram_we=1, ram_addr=5, wr_ack pulse. A later fetch of (h=40, v=0) returns 8'h5A.
4. wr_req asserted in a fetch slot -> wr_ack=0 and ram_we=0 that cycle. The write is granted in the next free cycle.
5. wr_req with wr_addr=2400 -> wr_ack pulse, ram_we stays 0.
6. clr_req at clr_addr=1000 mid-clear, then reset asserted mid-clear -> clr_req ignored. Clear restarts from 0 after reset; wr_req issued during CLEAR is only acked after clr_busy falls.
